ctr_ahb_master: RTL and testbench

- Bridge from the core-side CtrBus/DatBus request protocol (req/gnt/rvalid/err) to an AHB3-lite master port.
- This is the initiator end for AHB3-lite slaves such as the timers. bus_mux instantiates one per AHB3-lite slave so the data port can reach AHB peripherals.
- At most one outstanding transfer. Address and data phases are registered. Wait states and two-cycle ERROR responses are honoured.

---
 rtl/ctr_ahb_master_pkg.sv | 27 ++
 rtl/ctr_ahb_master_if.sv | 33 +++
 rtl/ctr_ahb_master.sv | 56 +++++
 tb/tb_ctr_ahb_master.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ctr_ahb_master_pkg.sv
// ctr_ahb_master_pkg: AHB3-lite constants, bridge FSM states and byte-enable decode.
package ctr_ahb_master_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR, ST_LERR} state_t;
  typedef struct packed {
    logic valid;
    logic [2:0] hsize;
    logic [1:0] addr_lo;
  } xfer_size_t;
  // Unsupported patterns fall back to an aligned word; only writes treat them as errors.
  function automatic xfer_size_t be2size(input logic [3:0] be);
    case (be)
      4'b1111: return '{1'b1, HSIZE_WORD, 2'b00};
      4'b0011: return '{1'b1, HSIZE_HALF, 2'b00};
      4'b1100: return '{1'b1, HSIZE_HALF, 2'b10};
      4'b0001: return '{1'b1, HSIZE_BYTE, 2'b00};
      4'b0010: return '{1'b1, HSIZE_BYTE, 2'b01};
      4'b0100: return '{1'b1, HSIZE_BYTE, 2'b10};
      4'b1000: return '{1'b1, HSIZE_BYTE, 2'b11};
      default: return '{1'b0, HSIZE_WORD, 2'b00};
    endcase
  endfunction
endpackage

// File: rtl/ctr_ahb_master_if.sv
// ctr_ahb_master_if: core-side request bus and AHB3-lite master bus interfaces.
interface ctr_bus_if #(parameter int HADDR_SIZE = 32);
  logic req;
  logic gnt;
  logic rvalid;
  logic we;
  logic [3:0] be;
  logic [HADDR_SIZE-1:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic err;
  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

interface ahb3lite_if #(parameter int HADDR_SIZE = 32, parameter int HDATA_SIZE = 32);
  logic HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic HWRITE;
  logic [2:0] HSIZE;
  logic [2:0] HBURST;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  logic HMASTLOCK;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic HREADY;
  logic HRESP;
  modport master (output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
                  input HRDATA, HREADY, HRESP);
  modport slave (input HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
                 output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ctr_ahb_master.sv
// ctr_ahb_master: bridges core req/gnt/rvalid requests onto an AHB3-lite master port,
// one outstanding transfer, registered address and data phases.
module ctr_ahb_master
  import ctr_ahb_master_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic clk,
  input logic rst,
  ctr_bus_if.slave core,
  ahb3lite_if.master ahb
);
  state_t state, nxt;
  xfer_size_t sz;
  logic gnt, done, unused_lo;
  assign sz = be2size(core.be);
  assign unused_lo = ^core.addr[1:0];
  // done: the data phase (normal or second ERROR cycle) ends this cycle
  assign done = ahb.HREADY && (state == ST_DATA || state == ST_ERR);
  assign gnt = core.req && (state == ST_IDLE || done);
  assign core.gnt = gnt;
  assign core.rvalid = done || state == ST_LERR;
  assign core.err = core.rvalid && (state != ST_DATA || ahb.HRESP);
  assign core.rdata = core.rvalid ? ahb.HRDATA[HDATA_SIZE-1:0] : '0;
  assign ahb.HSEL = state == ST_ADDR;
  assign ahb.HTRANS = ahb.HSEL ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.HBURST = 3'b000;
  assign ahb.HPROT = HPROT_VAL;
  assign ahb.HMASTLOCK = 1'b0;
  always_comb begin
    nxt = state;
    if (gnt) nxt = (core.we && !sz.valid) ? ST_LERR : ST_ADDR;
    else if (done || state == ST_LERR) nxt = ST_IDLE;
    else if (state == ST_ADDR) nxt = ahb.HREADY ? ST_DATA : ST_ADDR;
    else if (state == ST_DATA && ahb.HRESP) nxt = ST_ERR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ahb.HADDR <= '0;
      ahb.HWRITE <= 1'b0;
      ahb.HSIZE <= HSIZE_WORD;
      ahb.HWDATA <= '0;
    end else begin
      state <= nxt;
      if (gnt) begin
        ahb.HADDR <= {core.addr[HADDR_SIZE-1:2], sz.addr_lo};
        ahb.HWRITE <= core.we;
        ahb.HSIZE <= sz.hsize;
        ahb.HWDATA <= core.wdata;
      end
    end
  end
endmodule

// File: tb/tb_ctr_ahb_master.sv
// tb_ctr_ahb_master: scoreboard bench with a wait-state/ERROR capable AHB slave model.
module tb_ctr_ahb_master;
  localparam logic [31:0] IDLE_RD = 32'h0BAD_0BAD;
  typedef struct {logic err; logic [31:0] rd; int lat;} rsp_t;
  typedef struct {logic [31:0] haddr; logic [2:0] hsize; logic hwrite; logic [31:0] wd;} adr_t;
  typedef struct {int w; logic e; logic [31:0] rd;} cfg_t;
  logic clk, rst;
  int cyc = 0, nchecks = 0, nerrors = 0;
  rsp_t rq[$];
  adr_t aq[$];
  cfg_t cq[$];
  int gq[$];
  adr_t cur_a;
  cfg_t sc;
  rsp_t r;
  int g, d;
  logic sdph = 0, nx_rdy = 1, nx_resp = 0;
  logic [31:0] nx_rd = IDLE_RD;
  ctr_bus_if c ();
  ahb3lite_if h ();
  ctr_ahb_master dut (.clk(clk), .rst(rst), .core(c.slave), .ahb(h.master));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // {legal, hsize, addr_lo} for each byte-enable pattern
  function automatic logic [5:0] model(input logic [3:0] b);
    case (b)
      4'hF: return 6'b1_010_00;
      4'h3: return 6'b1_001_00;
      4'hC: return 6'b1_001_10;
      4'h1: return 6'b1_000_00;
      4'h2: return 6'b1_000_01;
      4'h4: return 6'b1_000_10;
      4'h8: return 6'b1_000_11;
      default: return 6'b0_010_00;
    endcase
  endfunction
  // Monitor, scoreboard and slave sequencer all sample mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      rq.delete(); aq.delete(); cq.delete(); gq.delete();
      sdph = 0;
    end else begin
      if (c.req && c.gnt) gq.push_back(cyc);
      if (c.rvalid) begin
        if (rq.size() == 0 || gq.size() == 0) check("spurious_rvalid", 1, 0);
        else begin
          r = rq.pop_front();
          g = gq.pop_front();
          check("err", c.err, r.err);
          check("rdata", c.rdata, r.rd);
          check("latency", cyc - g, r.lat);
        end
      end else check("rdata_idle", c.rdata, 0);
      if (h.HTRANS == 2'b10) begin
        if (aq.size() == 0) check("spurious_nonseq", 1, 0);
        else begin
          check("haddr", h.HADDR, aq[0].haddr);
          check("hsize", h.HSIZE, aq[0].hsize);
          check("hwrite", h.HWRITE, aq[0].hwrite);
          check("hsel", h.HSEL, 1);
          check("hconst", {h.HBURST, h.HPROT, h.HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
          if (h.HREADY) cur_a = aq.pop_front();
        end
      end else check("htrans_idle", {h.HTRANS, h.HSEL}, 0);
      if (sdph && cur_a.hwrite) check("hwdata", h.HWDATA, cur_a.wd);
      if (sdph) begin
        if (h.HREADY) sdph = 0;
        else d++;
      end
      if (h.HTRANS == 2'b10 && h.HSEL && h.HREADY) begin
        sc = (cq.size() > 0) ? cq.pop_front() : '{0, 1'b0, 32'h0};
        sdph = 1;
        d = 0;
      end
    end
    nx_rdy = !sdph || d == sc.w + int'(sc.e);
    nx_resp = sdph && sc.e && d >= sc.w;
    nx_rd = sdph ? sc.rd : IDLE_RD;
  end
  initial forever begin
    @(posedge clk);
    #1;
    h.HREADY = nx_rdy;
    h.HRESP = nx_resp;
    h.HRDATA = nx_rd;
  end
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] wd,
                       input int ws, input logic e, input logic [31:0] rd, output int gc);
    logic [5:0] m;
    m = model(b);
    if (w && !m[5]) rq.push_back('{1'b1, IDLE_RD, 1});
    else begin
      aq.push_back('{{a[31:2], m[1:0]}, m[4:2], w, wd});
      cq.push_back('{ws, e, rd});
      rq.push_back('{e, rd, 2 + ws + int'(e)});
    end
    c.req = 1; c.we = w; c.be = b; c.addr = a; c.wdata = wd;
    gc = -1;
    for (int i = 0; i < 64 && gc < 0; i++) begin
      @(negedge clk);
      if (c.gnt) gc = cyc;
      @(posedge clk);
      #1;
    end
    if (gc < 0) check("gnt_timeout", 0, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && rq.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain", rq.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int gc;
    int gs[4];
    logic [3:0] bl[11];
    bl = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h7, 4'hE, 4'h6, 4'h0};
    rst = 1; c.req = 0; c.we = 0; c.be = 0; c.addr = 0; c.wdata = 0;
    h.HREADY = 1; h.HRESP = 0; h.HRDATA = IDLE_RD;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("rst_htrans", h.HTRANS, 0);
    check("rst_hsel", h.HSEL, 0);
    check("rst_haddr", h.HADDR, 0);
    check("rst_hwrite", h.HWRITE, 0);
    check("rst_hsize", h.HSIZE, 3'b010);
    check("rst_hwdata", h.HWDATA, 0);
    check("rst_gnt", c.gnt, 0);
    check("rst_rvalid_err", {c.rvalid, c.err}, 0);
    check("rst_rdata", c.rdata, 0);
    @(posedge clk);
    #1;
    issue(0, 4'hF, 32'h8000_0010, 0, 0, 0, 32'hDEAD_BEEF, gc);
    c.req = 0;
    drain();
    issue(1, 4'h4, 32'h8000_0014, 32'h00AB_0000, 3, 0, 32'h1234_5678, gc);
    c.req = 0;
    drain();
    issue(0, 4'hF, 32'h8000_0020, 0, 0, 1, 32'h5555_AAAA, gc);
    c.req = 0;
    drain();
    issue(1, 4'h7, 32'h8000_0030, 32'hCAFE_F00D, 0, 0, 0, gc);
    c.req = 0;
    drain();
    issue(0, 4'h7, 32'h8000_001B, 0, 0, 0, 32'h0102_0304, gc);
    c.req = 0;
    drain();
    for (int i = 0; i < 4; i++) issue(0, 4'hF, 32'h4000_0000 + 32'(i * 4), 0, 0, 0, 32'hA000_0000 + 32'(i), gs[i]);
    c.req = 0;
    for (int i = 1; i < 4; i++) check("b2b_gnt_spacing", gs[i] - gs[i-1], 2);
    drain();
    issue(0, 4'hF, 32'h8000_0040, 0, 6, 0, 32'h7777_7777, gc);
    c.req = 0;
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("abort_htrans", h.HTRANS, 0);
    check("abort_rvalid", c.rvalid, 0);
    repeat (8) @(posedge clk);
    #1;
    issue(0, 4'hC, 32'h8000_0044, 0, 1, 0, 32'h9999_0000, gc);
    c.req = 0;
    drain();
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), bl[$urandom_range(0, 10)], $urandom, $urandom,
            $urandom_range(0, 3), ($urandom_range(0, 4) == 0), $urandom, gc);
      if ($urandom_range(0, 2) == 0) begin
        c.req = 0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    c.req = 0;
    drain();
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
